// File: rtl/sfu_csr_pkg.sv
// Shared types for the SFU CSR unit: op encodings, per-lane data and the result entry.
// The build-time option SFU_CSR_SKID_EN (see sfu_csr_out_buf) does not change anything here.
package sfu_csr_pkg;

   localparam int SFU_NUM_LANES  = 4;
   localparam int SFU_NUM_WARPS  = 4;
   localparam int SFU_WID_W      = (SFU_NUM_WARPS > 1) ? $clog2(SFU_NUM_WARPS) : 1;
   localparam int SFU_PID_WIDTH  = 1;
   localparam int SFU_ADDR_BITS  = 12;
   localparam int SFU_UUID_WIDTH = 44;

   typedef enum logic [1:0] {
      CSR_OP_RW = 2'b00,
      CSR_OP_RS = 2'b01,
      CSR_OP_RC = 2'b10
   } csr_op_e;

   typedef logic [31:0] csr_word_t;
   typedef csr_word_t [SFU_NUM_LANES-1:0] csr_lanes_t;

   typedef struct packed {
      logic [SFU_UUID_WIDTH-1:0] uuid;
      logic [SFU_WID_W-1:0]      wid;
      logic [SFU_NUM_LANES-1:0]  tmask;
      logic [SFU_PID_WIDTH-1:0]  pid;
      logic [4:0]                rd;
      csr_lanes_t                data;
   } csr_entry_t;

   function automatic csr_word_t csr_lane_wdata(csr_op_e op, csr_word_t rd, csr_word_t src);
      case (op)
         CSR_OP_RS: return rd | src;
         CSR_OP_RC: return rd & ~src;
         default:   return src;
      endcase
   endfunction

endpackage

// File: rtl/sfu_csr_out_buf.sv
// Valid/ready result buffer holding csr_entry_t. SFU_CSR_SKID_EN selects a 2-entry FIFO
// whose in_ready ignores out_ready; otherwise a single pipeline register.
module sfu_csr_out_buf
   import sfu_csr_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  csr_entry_t in_entry,
   output logic       out_valid,
   input  logic       out_ready,
   output csr_entry_t out_entry
);

   logic push;
   logic pop;

   assign push = in_valid && in_ready;
   assign pop  = out_valid && out_ready;

`ifdef SFU_CSR_SKID_EN
   logic [1:0] count_reg;
   csr_entry_t slot0_reg;
   csr_entry_t slot1_reg;

   assign in_ready  = (count_reg != 2'd2);
   assign out_valid = (count_reg != 2'd0);
   assign out_entry = slot0_reg;

   // slot0 is always the head; slot1 only holds the second-oldest entry.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_reg <= 2'd0;
         slot0_reg <= '0;
         slot1_reg <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count_reg == 2'd0) slot0_reg <= in_entry;
               else                   slot1_reg <= in_entry;
               count_reg <= count_reg + 2'd1;
            end
            2'b01: begin
               slot0_reg <= slot1_reg;
               count_reg <= count_reg - 2'd1;
            end
            2'b11: begin
               if (count_reg == 2'd1) begin
                  slot0_reg <= in_entry;
               end else begin
                  slot0_reg <= slot1_reg;
                  slot1_reg <= in_entry;
               end
            end
            default: ;
         endcase
      end
   end
`else
   logic       valid_reg;
   csr_entry_t entry_reg;

   assign in_ready  = !valid_reg || out_ready;
   assign out_valid = valid_reg;
   assign out_entry = entry_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_reg <= 1'b0;
         entry_reg <= '0;
      end else if (push) begin
         valid_reg <= 1'b1;
         entry_reg <= in_entry;
      end else if (out_ready) begin
         valid_reg <= 1'b0;
      end
   end
`endif

endmodule

// File: rtl/sfu_csr_unit.sv
// SFU CSR channel driver: one combined read + optional write per accepted request, old
// value returned through sfu_csr_out_buf (depth set by SFU_CSR_SKID_EN).
module sfu_csr_unit
   import sfu_csr_pkg::*;
#(
   parameter  int NUM_LANES  = SFU_NUM_LANES,
   parameter  int NUM_WARPS  = SFU_NUM_WARPS,
   parameter  int PID_WIDTH  = SFU_PID_WIDTH,
   parameter  int ADDR_BITS  = SFU_ADDR_BITS,
   parameter  int UUID_WIDTH = SFU_UUID_WIDTH,
   localparam int WID_W      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
)(
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [UUID_WIDTH-1:0]       in_uuid,
   input  logic [WID_W-1:0]            in_wid,
   input  logic [NUM_LANES-1:0]        in_tmask,
   input  logic [PID_WIDTH-1:0]        in_pid,
   input  logic [4:0]                  in_rd,
   input  logic [1:0]                  in_op,
   input  logic [ADDR_BITS-1:0]        in_addr,
   input  logic                        in_use_imm,
   input  logic [4:0]                  in_imm,
   input  logic                        in_rs1_x0,
   input  logic [NUM_LANES-1:0][31:0]  in_rs1_data,
   output logic                        csr_read_enable,
   output logic [UUID_WIDTH-1:0]       csr_read_uuid,
   output logic [WID_W-1:0]            csr_read_wid,
   output logic [NUM_LANES-1:0]        csr_read_tmask,
   output logic [PID_WIDTH-1:0]        csr_read_pid,
   output logic [ADDR_BITS-1:0]        csr_read_addr,
   input  logic [NUM_LANES-1:0][31:0]  csr_read_data,
   output logic                        csr_write_enable,
   output logic [UUID_WIDTH-1:0]       csr_write_uuid,
   output logic [WID_W-1:0]            csr_write_wid,
   output logic [NUM_LANES-1:0]        csr_write_tmask,
   output logic [PID_WIDTH-1:0]        csr_write_pid,
   output logic [ADDR_BITS-1:0]        csr_write_addr,
   output logic [NUM_LANES-1:0][31:0]  csr_write_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [UUID_WIDTH-1:0]       out_uuid,
   output logic [WID_W-1:0]            out_wid,
   output logic [NUM_LANES-1:0]        out_tmask,
   output logic [PID_WIDTH-1:0]        out_pid,
   output logic [4:0]                  out_rd,
   output logic [NUM_LANES-1:0][31:0]  out_data
);

   logic       fire;
   logic       no_write;
   csr_op_e    op_eff;
   csr_lanes_t captured_data;
   csr_entry_t push_entry;
   csr_entry_t head_entry;

   assign fire = in_valid && in_ready;

   // The reserved encoding 2'b11 behaves exactly like RW.
   always_comb begin
      op_eff = CSR_OP_RW;
      case (in_op)
         2'b01:   op_eff = CSR_OP_RS;
         2'b10:   op_eff = CSR_OP_RC;
         default: ;
      endcase
   end

   assign no_write = (op_eff != CSR_OP_RW) && (in_use_imm ? (in_imm == 5'd0) : in_rs1_x0);

   assign csr_read_enable  = fire;
   assign csr_read_uuid    = in_uuid;
   assign csr_read_wid     = in_wid;
   assign csr_read_tmask   = in_tmask;
   assign csr_read_pid     = in_pid;
   assign csr_read_addr    = in_addr;

   assign csr_write_enable = fire && !no_write;
   assign csr_write_uuid   = in_uuid;
   assign csr_write_wid    = in_wid;
   assign csr_write_tmask  = in_tmask;
   assign csr_write_pid    = in_pid;
   assign csr_write_addr   = in_addr;

   for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      csr_word_t src;
      assign src = in_use_imm ? {27'b0, in_imm} : in_rs1_data[gi];
      assign csr_write_data[gi] = in_tmask[gi] ? csr_lane_wdata(op_eff, csr_read_data[gi], src) : 32'd0;
      assign captured_data[gi]  = in_tmask[gi] ? csr_read_data[gi] : 32'd0;
   end

   assign push_entry = '{uuid: in_uuid, wid: in_wid, tmask: in_tmask, pid: in_pid,
                         rd: in_rd, data: captured_data};

   sfu_csr_out_buf u_out_buf (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_entry  (push_entry),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_entry (head_entry)
   );

   assign out_uuid  = head_entry.uuid;
   assign out_wid   = head_entry.wid;
   assign out_tmask = head_entry.tmask;
   assign out_pid   = head_entry.pid;
   assign out_rd    = head_entry.rd;
   assign out_data  = head_entry.data;

endmodule

// File: tb/tb_sfu_csr_unit.sv
// Self-checking bench for sfu_csr_unit: behavioural slave + result queue model, random
// and directed stimulus. Honours SFU_CSR_SKID_EN for the expected buffer depth.
module tb_sfu_csr_unit;

`ifdef SFU_CSR_SKID_EN
   localparam int DEPTH = 2;
`else
   localparam int DEPTH = 1;
`endif

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              in_valid, in_ready;
   logic [43:0]       in_uuid;
   logic [1:0]        in_wid;
   logic [3:0]        in_tmask;
   logic [0:0]        in_pid;
   logic [4:0]        in_rd;
   logic [1:0]        in_op;
   logic [11:0]       in_addr;
   logic              in_use_imm;
   logic [4:0]        in_imm;
   logic              in_rs1_x0;
   logic [3:0][31:0]  in_rs1_data;
   logic              csr_read_enable;
   logic [43:0]       csr_read_uuid;
   logic [1:0]        csr_read_wid;
   logic [3:0]        csr_read_tmask;
   logic [0:0]        csr_read_pid;
   logic [11:0]       csr_read_addr;
   logic [3:0][31:0]  csr_read_data;
   logic              csr_write_enable;
   logic [43:0]       csr_write_uuid;
   logic [1:0]        csr_write_wid;
   logic [3:0]        csr_write_tmask;
   logic [0:0]        csr_write_pid;
   logic [11:0]       csr_write_addr;
   logic [3:0][31:0]  csr_write_data;
   logic              out_valid, out_ready;
   logic [43:0]       out_uuid;
   logic [1:0]        out_wid;
   logic [3:0]        out_tmask;
   logic [0:0]        out_pid;
   logic [4:0]        out_rd;
   logic [3:0][31:0]  out_data;

   always #5 clk = ~clk;

   sfu_csr_unit dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_uuid(in_uuid), .in_wid(in_wid), .in_tmask(in_tmask), .in_pid(in_pid), .in_rd(in_rd),
      .in_op(in_op), .in_addr(in_addr), .in_use_imm(in_use_imm), .in_imm(in_imm),
      .in_rs1_x0(in_rs1_x0), .in_rs1_data(in_rs1_data),
      .csr_read_enable(csr_read_enable), .csr_read_uuid(csr_read_uuid), .csr_read_wid(csr_read_wid),
      .csr_read_tmask(csr_read_tmask), .csr_read_pid(csr_read_pid), .csr_read_addr(csr_read_addr),
      .csr_read_data(csr_read_data),
      .csr_write_enable(csr_write_enable), .csr_write_uuid(csr_write_uuid), .csr_write_wid(csr_write_wid),
      .csr_write_tmask(csr_write_tmask), .csr_write_pid(csr_write_pid), .csr_write_addr(csr_write_addr),
      .csr_write_data(csr_write_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_uuid(out_uuid), .out_wid(out_wid), .out_tmask(out_tmask), .out_pid(out_pid), .out_rd(out_rd),
      .out_data(out_data)
   );

   typedef struct packed {
      logic [43:0]      uuid;
      logic [1:0]       wid;
      logic [3:0]       tmask;
      logic [0:0]       pid;
      logic [4:0]       rd;
      logic [3:0][31:0] data;
   } ent_t;

   ent_t        q[$];
   bit   [31:0] mem [4096][4];
   logic [31:0] dlog_data[$];
   logic [43:0] dlog_uuid[$];
   int          checks = 0;
   int          failures = 0;
   logic        preset_en = 1'b0;
   logic [11:0] preset_addr = '0;
   logic [31:0] preset_val = '0;

   // CSR slave: combinational read of the current (pre-write) contents.
   always_comb begin
      for (int l = 0; l < 4; l++) csr_read_data[l] = mem[csr_read_addr][l];
   end

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit model_ready();
      if (DEPTH == 2) return q.size() < 2;
      return (q.size() == 0) || out_ready;
   endfunction

   function automatic bit model_writes();
      return !(((in_op == 2'd1) || (in_op == 2'd2)) && (in_use_imm ? (in_imm == 5'd0) : in_rs1_x0));
   endfunction

   function automatic logic [31:0] model_wdata(int l);
      logic [31:0] old_v, s;
      old_v = mem[in_addr][l];
      s = in_use_imm ? {27'd0, in_imm} : in_rs1_data[l];
      if (!in_tmask[l]) return 32'd0;
      if (in_op == 2'd1) return old_v | s;
      if (in_op == 2'd2) return old_v & ~s;
      return s;
   endfunction

   // Model update: result queue and slave contents advance at each clock edge.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q.delete();
      end else begin
         bit   rdy;
         ent_t e;
         rdy = model_ready();
         if (q.size() != 0 && out_ready) void'(q.pop_front());
         if (in_valid && rdy) begin
            e.uuid = in_uuid; e.wid = in_wid; e.tmask = in_tmask; e.pid = in_pid; e.rd = in_rd;
            for (int l = 0; l < 4; l++) e.data[l] = in_tmask[l] ? mem[in_addr][l] : 32'd0;
            if (model_writes())
               for (int l = 0; l < 4; l++) if (in_tmask[l]) mem[in_addr][l] <= model_wdata(l);
            q.push_back(e);
         end
         if (preset_en)
            for (int l = 0; l < 4; l++) mem[preset_addr][l] <= preset_val;
      end
   end

   // Compare process: every cycle out of reset, checked mid-cycle.
   always @(negedge clk) begin
      if (reset_n === 1'b1) begin
         bit               rdy, f;
         logic [3:0][31:0] ew;
         rdy = model_ready();
         f = in_valid && rdy;
         chk("in_ready", in_ready, rdy);
         chk("rd_en", csr_read_enable, f);
         chk("wr_en", csr_write_enable, f && model_writes());
         if (f) begin
            for (int l = 0; l < 4; l++) ew[l] = model_wdata(l);
            chk("rd_addr", csr_read_addr, in_addr);
            chk("rd_tags", {csr_read_uuid, csr_read_wid, csr_read_tmask, csr_read_pid},
                {in_uuid, in_wid, in_tmask, in_pid});
            chk("wr_tags", {csr_write_uuid, csr_write_wid, csr_write_tmask, csr_write_pid, csr_write_addr},
                {in_uuid, in_wid, in_tmask, in_pid, in_addr});
            if (model_writes()) chk("wr_data", csr_write_data, ew);
         end
         chk("out_valid", out_valid, q.size() != 0);
         if (q.size() != 0) begin
            chk("out_tags", {out_uuid, out_wid, out_tmask, out_pid, out_rd},
                {q[0].uuid, q[0].wid, q[0].tmask, q[0].pid, q[0].rd});
            chk("out_data", out_data, q[0].data);
         end
         if (out_valid && out_ready) begin
            dlog_data.push_back(out_data[0]);
            dlog_uuid.push_back(out_uuid);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic [1:0] op, input logic [11:0] addr, input logic use_imm,
                          input logic [4:0] imm, input logic x0, input logic [3:0] tmask,
                          input logic [3:0][31:0] rs1, input logic [43:0] uuid);
      in_valid = 1'b1; in_op = op; in_addr = addr; in_use_imm = use_imm; in_imm = imm;
      in_rs1_x0 = x0; in_tmask = tmask; in_rs1_data = rs1; in_uuid = uuid;
      in_wid = uuid[1:0]; in_pid = uuid[2:2]; in_rd = uuid[7:3];
   endtask

   task automatic preset(input logic [11:0] addr, input logic [31:0] val);
      preset_en = 1'b1; preset_addr = addr; preset_val = val;
      step();
      preset_en = 1'b0;
   endtask

   initial begin
      int          acc, n0;
      logic [11:0] addrs [4];
      addrs[0] = 12'h005; addrs[1] = 12'h006; addrs[2] = 12'h300; addrs[3] = 12'hC00;
      in_valid = 0; in_op = 0; in_addr = 0; in_use_imm = 0; in_imm = 0; in_rs1_x0 = 0;
      in_tmask = 0; in_rs1_data = '0; in_uuid = 0; in_wid = 0; in_pid = 0; in_rd = 0;
      out_ready = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_data", out_data, 128'd0);
      chk("rst_rd_en", csr_read_enable, 1'b0);
      reset_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1'b1);

      // CSRRS 0x005, tmask 0101, rs1 {1,2,4,8}, slave 0x10
      step();
      preset(12'h005, 32'h10);
      set_req(2'd1, 12'h005, 1'b0, 5'd0, 1'b0, 4'b0101, {32'h8, 32'h4, 32'h2, 32'h1}, 44'd100);
      @(negedge clk);
      chk("rs_wr_en", csr_write_enable, 1'b1);
      chk("rs_wdata", csr_write_data, {32'h0, 32'h14, 32'h0, 32'h11});
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk("rs_out_valid", out_valid, 1'b1);
      chk("rs_out_data", out_data, {32'h0, 32'h10, 32'h0, 32'h10});

      // CSRRCI with imm 0 reads only; CSRRW from x0 still writes zero
      step();
      set_req(2'd2, 12'h006, 1'b1, 5'd0, 1'b0, 4'hF, '0, 44'd110);
      @(negedge clk);
      chk("rci0_rd_en", csr_read_enable, 1'b1);
      chk("rci0_wr_en", csr_write_enable, 1'b0);
      step();
      set_req(2'd0, 12'h006, 1'b0, 5'd0, 1'b1, 4'hF, '0, 44'd111);
      @(negedge clk);
      chk("rwx0_wr_en", csr_write_enable, 1'b1);
      chk("rwx0_wdata", csr_write_data, 128'd0);
      step();
      in_valid = 1'b0;

      // Output stall for 4 cycles with requests pending
      step();
      out_ready = 1'b0;
      acc = 0;
      n0 = dlog_uuid.size();
      for (int i = 0; i < 4; i++) begin
         set_req(2'd1, 12'h300, 1'b0, 5'd0, 1'b0, 4'hF, {4{32'(i + 1)}}, 44'd120 + 44'(acc));
         @(negedge clk);
         if (in_valid && in_ready) acc++;
         step();
      end
      chk("stall_accepts", acc, DEPTH);
      chk("stall_in_ready", in_ready, 1'b0);
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (4) step();
      chk("stall_delivered", dlog_uuid.size() - n0, DEPTH);
      chk("stall_order0", dlog_uuid[n0], 44'd120);

      // Back-to-back CSRRS to 0x005: src 1 then 2 from zero
      preset(12'h005, 32'h0);
      n0 = dlog_data.size();
      set_req(2'd1, 12'h005, 1'b0, 5'd0, 1'b0, 4'hF, {4{32'h1}}, 44'd200);
      @(negedge clk);
      chk("b2b_wdata0", csr_write_data[0], 32'h1);
      step();
      set_req(2'd1, 12'h005, 1'b0, 5'd0, 1'b0, 4'hF, {4{32'h2}}, 44'd201);
      @(negedge clk);
      chk("b2b_wdata1", csr_write_data[0], 32'h3);
      step();
      in_valid = 1'b0;
      repeat (2) step();
      chk("b2b_out0", dlog_data[n0], 32'h0);
      chk("b2b_out1", dlog_data[n0 + 1], 32'h1);
      chk("b2b_final", mem[12'h005][0], 32'h3);

      // Full-throughput stream of 16
      acc = 0;
      n0 = dlog_uuid.size();
      for (int i = 0; i < 16; i++) begin
         set_req(2'($urandom_range(0, 3)), addrs[i % 4], 1'($urandom), 5'($urandom), 1'b0,
                 4'($urandom), {$urandom, $urandom, $urandom, $urandom}, 44'd300 + 44'(i));
         @(negedge clk);
         if (in_valid && in_ready) acc++;
         step();
      end
      in_valid = 1'b0;
      repeat (2) step();
      chk("stream_accepts", acc, 16);
      chk("stream_delivered", dlog_uuid.size() - n0, 16);
      for (int i = 0; i < 16; i++) chk("stream_uuid", dlog_uuid[n0 + i], 44'd300 + 44'(i));

      // Randomized traffic against the model
      for (int i = 0; i < 4; i++) preset(addrs[i], $urandom);
      for (int i = 0; i < 300; i++) begin
         set_req(2'($urandom_range(0, 3)), addrs[$urandom_range(0, 3)], 1'($urandom),
                 ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), ($urandom_range(0, 3) == 0),
                 4'($urandom), {$urandom, $urandom, $urandom, $urandom}, {12'($urandom), $urandom});
         in_valid = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (4) step();

      // Asynchronous reset while a result is held
      out_ready = 1'b0;
      set_req(2'd0, 12'h006, 1'b0, 5'd0, 1'b0, 4'hF, {4{32'hABCD}}, 44'd900);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk("mid_out_valid", out_valid, 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_out_valid", out_valid, 1'b0);
      chk("arst_out_data", out_data, 128'd0);
      chk("arst_out_uuid", out_uuid, 44'd0);
      chk("arst_rd_en", csr_read_enable, 1'b0);
      @(posedge clk);
      #2;
      reset_n = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", in_ready, 1'b1);
      chk("post_rst_out_valid", out_valid, 1'b0);
      repeat (2) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
